spi_mstr: RTL and testbench

//  SPI master that serves the digital core's wrt_SPI/SPI_done request port. Serialises 16-bit
//  SPI_data (trigger/gain pots, calibration EEPROM) and deserialises MISO into rd_data.

---
 rtl/spi_pkg.sv | 33 +++
 rtl/spi_sclk_div.sv | 37 +++
 rtl/spi_mstr.sv | 136 +++++++++++++
 tb/tb_spi_mstr.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master: FSM states, slave codes
// and the slave-select decode.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    BACK  = 2'd3
  } state_t;

  localparam logic [2:0] SS_TRIG = 3'b000;
  localparam logic [2:0] SS_CH1  = 3'b001;
  localparam logic [2:0] SS_CH2  = 3'b010;
  localparam logic [2:0] SS_CH3  = 3'b011;
  localparam logic [2:0] SS_EEP  = 3'b100;

  // Slave code to active-low select vector; unused codes select nobody.
  function automatic logic [4:0] ss_decode(input logic [2:0] code);
    logic [4:0] sel_n;
    sel_n = 5'b11111;
    case (code)
      SS_TRIG: sel_n = 5'b11110;
      SS_CH1:  sel_n = 5'b11101;
      SS_CH2:  sel_n = 5'b11011;
      SS_CH3:  sel_n = 5'b10111;
      SS_EEP:  sel_n = 5'b01111;
      default: sel_n = 5'b11111;
    endcase
    return sel_n;
  endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// SCLK divider: free-running counter whose MSB is the serial clock.
// Also reports the cycle before a rise/fall and the end of a half period.
module spi_sclk_div #(
  parameter int W = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic sclk,
  output logic rise_nxt,
  output logic fall_nxt,
  output logic half_done
);

  localparam logic [W-1:0] HP_M1 = W'((1 << (W-1)) - 1);

  logic [W-1:0] cnt;

  // Counter: clear wins over enable; holds when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // SCLK comes straight off the counter MSB, so it is glitch-free.
  assign sclk      = cnt[W-1];
  assign rise_nxt  = (cnt == HP_M1);
  assign fall_nxt  = (&cnt);
  assign half_done = (cnt == HP_M1);

endmodule

// File: rtl/spi_mstr.sv
// Mode-0 SPI master: 16-bit MSB-first transfer with five decoded active-low
// slave selects. Handshake: wrt_SPI is a one-clock request accepted only in
// IDLE; SPI_done is a level that rises when rd_data is valid and clears on the
// clock that accepts the next request.
module spi_mstr
  import spi_pkg::*;
#(
  parameter int SCLK_DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt_SPI,
  input  logic [15:0] SPI_data,
  input  logic [2:0]  ss,
  output logic        SPI_done,
  output logic [15:0] rd_data,
  output logic [7:0]  EEP_data,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic [4:0]  ss_n,
  output state_t      fsm_state
);

  state_t      state_q, state_d;
  logic [15:0] shft;
  logic [3:0]  bit_cnt;
  logic        miso_smp;

  logic div_clr, div_en;
  logic rise_nxt, fall_nxt, half_done;
  logic load, smp, shift, finish;

  spi_sclk_div #(.W(SCLK_DIV_W)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (div_clr),
    .en        (div_en),
    .sclk      (SCLK),
    .rise_nxt  (rise_nxt),
    .fall_nxt  (fall_nxt),
    .half_done (half_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-cycle datapath strobes.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    div_clr = 1'b0;
    div_en  = 1'b0;
    smp     = 1'b0;
    shift   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (wrt_SPI) begin
          load    = 1'b1;
          div_clr = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        div_en = 1'b1;
        if (half_done) begin
          div_clr = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        div_en = 1'b1;
        smp    = rise_nxt;
        if (fall_nxt) begin
          shift = 1'b1;
          if (bit_cnt == 4'd15) state_d = BACK;
        end
      end
      BACK: begin
        div_en = 1'b1;
        if (half_done) begin
          div_clr = 1'b1;
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: shift register, bit counter, MISO sample and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shft     <= '0;
      bit_cnt  <= '0;
      miso_smp <= 1'b0;
      MOSI     <= 1'b0;
      ss_n     <= 5'b11111;
      SPI_done <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (load) begin
        shft     <= SPI_data;
        bit_cnt  <= '0;
        MOSI     <= SPI_data[15];
        ss_n     <= ss_decode(ss);
        SPI_done <= 1'b0;
      end
      if (smp) begin
        miso_smp <= MISO;
      end
      if (shift) begin
        // Next MOSI bit changes on the same edge SCLK falls.
        shft    <= {shft[14:0], miso_smp};
        MOSI    <= shft[14];
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (finish) begin
        ss_n     <= 5'b11111;
        SPI_done <= 1'b1;
        rd_data  <= shft;
      end
    end
  end

  assign EEP_data  = rd_data[7:0];
  assign fsm_state = state_q;

endmodule

// File: tb/tb_spi_mstr.sv
// Directed bench for spi_mstr with a mode-0 slave model on the pins.
module tb_spi_mstr;
  import spi_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        wrt_SPI;
  logic [15:0] SPI_data;
  logic [2:0]  ss;
  logic        SPI_done;
  logic [15:0] rd_data;
  logic [7:0]  EEP_data;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [4:0]  ss_n;
  state_t      fsm_state;

  int n_total = 0;
  int n_bad   = 0;

  // slave model
  logic [15:0] slv_tx;
  logic [15:0] slv_rx;
  int          rise_cnt;

  spi_mstr dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wrt_SPI   (wrt_SPI),
    .SPI_data  (SPI_data),
    .ss        (ss),
    .SPI_done  (SPI_done),
    .rd_data   (rd_data),
    .EEP_data  (EEP_data),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .ss_n      (ss_n),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // slave: capture MOSI on rise, advance MISO after fall
  assign MISO = slv_tx[15];
  always @(posedge SCLK) begin
    slv_rx   <= {slv_rx[14:0], MOSI};
    rise_cnt = rise_cnt + 1;
  end
  always @(negedge SCLK) slv_tx <= {slv_tx[14:0], 1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Launch one transfer, optionally re-pulse wrt_SPI mid-flight, and check it.
  task automatic do_xfer(input string tag, input logic [15:0] data, input logic [2:0] code,
                         input logic [15:0] reply, input logic [4:0] exp_ssn,
                         input int repulse_at);
    int k;
    int done_at;
    bit ss_bad;
    @(negedge clk);
    slv_tx   = reply;
    rise_cnt = 0;
    SPI_data = data;
    ss       = code;
    wrt_SPI  = 1'b1;
    @(posedge clk); #1;
    wrt_SPI  = 1'b0;
    SPI_data = ~data;
    ss       = 3'b111;
    check({tag, "_done_clr"}, 32'(SPI_done), 32'd0);
    k = 0; done_at = -1; ss_bad = 0;
    while (k < 2000 && done_at < 0) begin
      if (k == repulse_at) begin
        wrt_SPI  = 1'b1;
        SPI_data = 16'hFFFF;
      end
      @(posedge clk); #1;
      k++;
      wrt_SPI = 1'b0;
      if (SPI_done) done_at = k;
      else if (ss_n !== exp_ssn) ss_bad = 1;
    end
    check({tag, "_latency"}, 32'(done_at), 32'd544);
    check({tag, "_ss_n_held"}, 32'(ss_bad), 32'd0);
    check({tag, "_rises"}, 32'(rise_cnt), 32'd16);
    check({tag, "_slave_rx"}, 32'(slv_rx), 32'(data));
    check({tag, "_rd_data"}, 32'(rd_data), 32'(reply));
    check({tag, "_eep"}, 32'(EEP_data), 32'(reply[7:0]));
    check({tag, "_ss_n_end"}, 32'(ss_n), 32'h1f);
    check({tag, "_sclk_end"}, 32'(SCLK), 32'd0);
  endtask

  initial begin
    int k;
    rst_n    = 1'b0;
    wrt_SPI  = 1'b0;
    SPI_data = '0;
    ss       = '0;
    slv_tx   = '0;
    slv_rx   = '0;
    rise_cnt = 0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ss_n", 32'(ss_n), 32'h1f);
    check("rst_sclk", 32'(SCLK), 32'd0);
    check("rst_mosi", 32'(MOSI), 32'd0);
    check("rst_done", 32'(SPI_done), 32'd0);
    check("rst_rd", 32'(rd_data), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("idle_no_sclk", 32'(rise_cnt), 32'd0);

    // ch2 transfer
    do_xfer("ch2", 16'h1346, 3'b010, 16'hA55A, 5'b11011, -1);

    // done level holds while idle
    repeat (20) @(posedge clk);
    #1;
    check("done_hold", 32'(SPI_done), 32'd1);
    check("rd_hold", 32'(rd_data), 32'hA55A);

    // EEPROM
    do_xfer("eep", 16'h0005, 3'b100, 16'h00C3, 5'b01111, -1);

    // re-pulse mid-transfer is ignored
    do_xfer("repulse", 16'h2B71, 3'b000, 16'h5C3E, 5'b11110, 200);

    // unused slave code
    do_xfer("none", 16'h8001, 3'b110, 16'h7E81, 5'b11111, -1);

    // reset during bit 7
    @(negedge clk);
    slv_tx   = 16'hFFFF;
    SPI_data = 16'hFFFF;
    ss       = 3'b011;
    wrt_SPI  = 1'b1;
    @(posedge clk); #1;
    wrt_SPI = 1'b0;
    for (k = 0; k < 250; k++) begin
      @(posedge clk);
    end
    #3;
    check("abort_ss_active", 32'(ss_n), 32'h17);
    rst_n = 1'b0;
    #1;
    check("abort_ss_n", 32'(ss_n), 32'h1f);
    check("abort_sclk", 32'(SCLK), 32'd0);
    check("abort_done", 32'(SPI_done), 32'd0);
    check("abort_rd", 32'(rd_data), 32'd0);
    check("abort_state", 32'(fsm_state), 32'(IDLE));
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    do_xfer("after_abort", 16'hC0DE, 3'b001, 16'h3A5C, 5'b11101, -1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
